// File: rtl/phase_pkg.sv
// Shared widths, FSM encoding and bin bundle for the FFT fundamental picker.
package phase_pkg;

    localparam int FFT_LEN_DEF = 1024;
    localparam int IDX_W_DEF   = 10;
    localparam int MAG_W       = 17;
    localparam int SMP_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [SMP_W-1:0] c1_re;
        logic signed [SMP_W-1:0] c1_im;
        logic signed [SMP_W-1:0] c2_re;
        logic signed [SMP_W-1:0] c2_im;
    } bins_t;

endpackage

// File: rtl/mag_approx.sv
// Combinational alpha-max/beta-min magnitude: max(|re|,|im|) + min(|re|,|im|)/2.
module mag_approx
    import phase_pkg::*;
(
    input  logic signed [SMP_W-1:0] i_re,
    input  logic signed [SMP_W-1:0] i_im,
    output logic        [MAG_W-1:0] o_mag
);

    // One extra bit so |-32768| is representable.
    function automatic logic [MAG_W-1:0] f_abs(input logic signed [SMP_W-1:0] v);
        logic signed [MAG_W-1:0] v_ext;
        v_ext = {v[SMP_W-1], v};
        return v[SMP_W-1] ? -v_ext : v_ext;
    endfunction

    logic [MAG_W-1:0] w_a;
    logic [MAG_W-1:0] w_b;
    logic [MAG_W-1:0] w_max;
    logic [MAG_W-1:0] w_min;

    assign w_a   = f_abs(i_re);
    assign w_b   = f_abs(i_im);
    assign w_max = (w_a >= w_b) ? w_a : w_b;
    assign w_min = (w_a >= w_b) ? w_b : w_a;
    assign o_mag = w_max + (w_min >> 1);

endmodule

// File: rtl/fft_fundamental_picker.sv
// Picks the strongest channel-1 bin of each FFT frame and emits both
// channels' values at that bin, guarding against index discontinuities.
module fft_fundamental_picker
    import phase_pkg::*;
#(
    parameter int               FFT_LEN    = FFT_LEN_DEF,
    parameter int               IDX_W      = IDX_W_DEF,
    parameter int               MIN_BIN    = 1,
    parameter logic [MAG_W-1:0] MAG_THRESH = 17'd64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    fft_valid,
    input  logic [IDX_W-1:0]        fft_index,
    input  logic                    fft_last,
    input  logic signed [SMP_W-1:0] fft1_re,
    input  logic signed [SMP_W-1:0] fft1_im,
    input  logic signed [SMP_W-1:0] fft2_re,
    input  logic signed [SMP_W-1:0] fft2_im,
    output logic signed [SMP_W-1:0] ch1_re,
    output logic signed [SMP_W-1:0] ch1_im,
    output logic signed [SMP_W-1:0] ch2_re,
    output logic signed [SMP_W-1:0] ch2_im,
    output logic                    ch1_valid,
    output logic                    ch2_valid,
    output logic [IDX_W-1:0]        peak_bin,
    output logic [MAG_W-1:0]        peak_mag,
    output logic                    signal_lost,
    output logic                    frame_err
);

    localparam logic [IDX_W-1:0] BIN_LO  = IDX_W'(MIN_BIN);
    localparam logic [IDX_W-1:0] BIN_HI  = IDX_W'(FFT_LEN / 2 - 1);
    localparam logic [IDX_W-1:0] BIN_END = IDX_W'(FFT_LEN - 1);

    logic [MAG_W-1:0] w_mag;
    logic [MAG_W-1:0] w_base;
    logic             w_start;
    logic             w_beat;
    logic             w_cand;
    logic             w_better;

    logic             r_p_valid;
    logic             r_p_last;
    logic [IDX_W-1:0] r_p_idx;
    logic [MAG_W-1:0] r_p_mag;
    bins_t            r_p_bins;

    state_t           r_state;
    logic [IDX_W-1:0] r_exp;
    logic [IDX_W-1:0] r_best_idx;
    logic [MAG_W-1:0] r_best_mag;
    bins_t            r_best;
    logic             r_done;

    bins_t            r_out;
    logic [IDX_W-1:0] r_peak_bin;
    logic [MAG_W-1:0] r_peak_mag;
    logic             r_strobe;
    logic             r_lost;
    logic             r_err;

    mag_approx u_mag (
        .i_re  (fft1_re),
        .i_im  (fft1_im),
        .o_mag (w_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_idx   <= '0;
            r_p_mag   <= '0;
            r_p_bins  <= '0;
        end else begin
            r_p_valid <= fft_valid;
            r_p_last  <= fft_last;
            r_p_idx   <= fft_index;
            r_p_mag   <= w_mag;
            r_p_bins  <= '{fft1_re, fft1_im, fft2_re, fft2_im};
        end
    end

    // A frame may only open on index 0; the best is measured from zero then.
    assign w_start  = (r_state == ST_IDLE) && r_p_valid && enable
                      && (r_p_idx == '0);
    assign w_beat   = w_start || ((r_state == ST_SCAN) && r_p_valid
                      && (r_p_idx == r_exp));
    assign w_cand   = (r_p_idx >= BIN_LO) && (r_p_idx <= BIN_HI);
    assign w_base   = w_start ? '0 : r_best_mag;
    assign w_better = w_cand && (r_p_mag > w_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_exp      <= '0;
            r_best_idx <= '0;
            r_best_mag <= '0;
            r_best     <= '0;
            r_done     <= 1'b0;
            r_out      <= '0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
            r_strobe   <= 1'b0;
            r_lost     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;

            if (r_done) begin
                if (r_best_mag >= MAG_THRESH) begin
                    r_out      <= r_best;
                    r_peak_bin <= r_best_idx;
                    r_peak_mag <= r_best_mag;
                    r_strobe   <= 1'b1;
                    r_lost     <= 1'b0;
                end else begin
                    r_lost     <= 1'b1;
                end
            end

            if ((r_state != ST_IDLE) && !enable) begin
                r_state <= ST_IDLE;
            end else if (w_beat) begin
                if (w_better) begin
                    r_best     <= r_p_bins;
                    r_best_idx <= r_p_idx;
                    r_best_mag <= r_p_mag;
                end else if (w_start) begin
                    r_best     <= '0;
                    r_best_idx <= '0;
                    r_best_mag <= '0;
                end
                r_exp <= r_p_idx + IDX_W'(1);
                if (r_p_last) begin
                    r_state <= ST_IDLE;
                    if (r_p_idx == BIN_END) begin
                        r_done <= 1'b1;
                    end else begin
                        r_err  <= 1'b1;
                    end
                end else begin
                    r_state <= ST_SCAN;
                end
            end else if ((r_state == ST_SCAN) && r_p_valid) begin
                r_err   <= 1'b1;
                r_state <= r_p_last ? ST_IDLE : ST_RESYNC;
            end else if ((r_state == ST_RESYNC) && r_p_valid && r_p_last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign ch1_re      = r_out.c1_re;
    assign ch1_im      = r_out.c1_im;
    assign ch2_re      = r_out.c2_re;
    assign ch2_im      = r_out.c2_im;
    assign ch1_valid   = r_strobe;
    assign ch2_valid   = r_strobe;
    assign peak_bin    = r_peak_bin;
    assign peak_mag    = r_peak_mag;
    assign signal_lost = r_lost;
    assign frame_err   = r_err;

endmodule

// File: doc/fft_fundamental_picker.md
FFT_FUNDAMENTAL_PICKER -- requirements
Module: fft_fundamental_picker

Interface
REQ-001 Parameter FFT_LEN, default 1024, FFT frame length in bins.
REQ-002 Parameter IDX_W, default 10, bin index width; equals log2(FFT_LEN).
REQ-003 Parameter MIN_BIN, default 1, lowest bin searched; DC is excluded.
REQ-004 Parameter MAG_THRESH, default 17'd64, minimum peak magnitude for emission.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  block enable.
REQ-008 fft_valid  in  1  input beat qualifier; both channels are aligned on the same beat.
REQ-009 fft_index  in  IDX_W  bin index of the current beat.
REQ-010 fft_last  in  1  final beat of the frame.
REQ-011 fft1_re, fft1_im, fft2_re, fft2_im  in  16 signed  channel 1 and channel 2 bin values.
REQ-012 ch1_re, ch1_im, ch2_re, ch2_im  out  16 signed  fundamental-bin values, registered.
REQ-013 ch1_valid, ch2_valid  out  1  one-cycle emission strobes, always asserted together.
REQ-014 peak_bin  out  IDX_W  index of the emitted fundamental.
REQ-015 peak_mag  out  17  magnitude of the emitted channel 1 peak.
REQ-016 signal_lost  out  1  level; set when a completed frame has its peak below MAG_THRESH.
REQ-017 frame_err  out  1  one-cycle pulse when a frame is aborted on an index discontinuity.

Function
REQ-018 Magnitude SHALL be max(|re|,|im|) + (min(|re|,|im|) >> 1), 17-bit unsigned, using channel 1 only; |-32768| = 32768.
REQ-019 Magnitude SHALL be a one-stage registered pipeline carrying re/im (both channels), index, last and valid.
REQ-020 The FSM SHALL have three states: IDLE, SCAN and RESYNC.
REQ-021 IDLE: beats with fft_index != 0 are ignored; a beat with fft_index == 0 and enable=1 enters SCAN, and that beat is processed.
REQ-022 SCAN: each beat's index SHALL equal the expected counter, which is 0 at frame start and +1 per beat.
REQ-023 On a SCAN index mismatch: pulse frame_err, discard the frame, enter RESYNC; no emission.
REQ-024 RESYNC: ignore beats until a beat with fft_last=1, then go to IDLE.
REQ-025 Only bins with MIN_BIN <= index <= FFT_LEN/2-1 are candidates; all other bins are ignored for peak search.
REQ-026 A candidate SHALL replace the stored best only if its magnitude is strictly greater, so the lowest index wins ties; the stored best includes channel 2 re/im from the same beat.
REQ-027 Best magnitude SHALL clear to 0 at every frame start.
REQ-028 fft_last sampled at edge k in SCAN with a valid frame: outputs SHALL register at edge k+2, strobes are high for exactly one cycle, and the FSM returns to IDLE.
REQ-029 If best magnitude < MAG_THRESH at frame end: no strobes, signal_lost=1, outputs hold their old values.
REQ-030 signal_lost SHALL clear on the next emission.
REQ-031 fft_last on a beat whose index != FFT_LEN-1 SHALL be treated as a mismatch: pulse frame_err, no emission, go to IDLE.
REQ-032 enable deasserted in SCAN or RESYNC: abort the frame immediately, go to IDLE, no emission, no frame_err; output data registers hold.
REQ-033 A beat with fft_index == 0 arriving in the same cycle as the emission of the previous frame SHALL start a new SCAN without loss.
REQ-034 fft_valid=0 cycles (gaps) SHALL be tolerated anywhere in a frame and SHALL NOT advance the expected index.

Reset
REQ-035 Asynchronous assertion of rst_n SHALL clear the FSM to IDLE, and clear all data outputs, peak_bin, peak_mag, strobes, signal_lost, frame_err, the pipeline valid and the best registers to 0.
REQ-036 Reset mid-frame SHALL discard the partial frame; the first emission after reset requires a full frame starting at index 0.

Structure
REQ-037 FFT_LEN/IDX_W defaults, the 17-bit magnitude width and the FSM state encoding SHALL live in shared package phase_pkg.
REQ-038 The magnitude approximation SHALL be a sub-module mag_approx (combinational core, registered in the parent).

Verification
REQ-039 Frame with tone at bin 37 (ch1 = 1000+0j, ch2 = 0+1000j), other bins 0 -> single strobe at k+2, peak_bin=37, peak_mag=1000, ch2_im=1000.
REQ-040 Bins 20 and 50 both at magnitude 800 -> peak_bin=20; DC bin at 30000 -> not selected.
REQ-041 All bins at magnitude 10 -> no strobe, signal_lost=1; next frame with bin 5 at 500 -> emission, signal_lost=0.
REQ-042 Index jumps from 99 to 101 -> frame_err pulse, no emission; the following clean frame emits normally.
REQ-043 enable low at bin 300, then high before the next index 0 -> no emission for the aborted frame, a correct emission for the next.
REQ-044 rst_n low at bin 200 -> all outputs 0 immediately; a fresh frame after release emits correctly.
